multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Main controller for the multicycle RV32I subset (lw, sw, R-type, I-type ALU, beq, jal) sharing one ALU and one memory port. A Moore state machine sequences fetch/decode/execute/memory/writeback. It drives the immediate extender's `immsrc`, the ALU source and result muxes, the memory address mux and all architectural write strobes.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; returns the FSM to FETCH
- `op`  in  7  instr[6:0], taken from the instruction register
- `funct3`  in  3  instr[14:12]
- `funct7b5`  in  1  instr[30]
- `zero`  in  1  ALU zero flag, same cycle
- `immsrc`  out  2  00 I, 01 S, 10 B, 11 J
- `alusrca`  out  2  00 PC, 01 OldPC, 10 rs1 data
- `alusrcb`  out  2  00 rs2 data, 01 immext, 10 constant 4
- `resultsrc`  out  2  00 ALUOut reg, 01 memory data reg, 10 ALU result
- `adrsrc`  out  1  0 PC, 1 result
- `alucontrol`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `irwrite`, `pcwrite`, `regwrite`, `memwrite`  out  1 each  write strobes
- `illegal`  out  1  one-cycle pulse in DECODE for an unsupported opcode

## Operation
- States and outputs; every unlisted signal is 0 or 00:
  - FETCH: irwrite=1, pcupdate=1, alusrcb=10, resultsrc=10.
  - DECODE: alusrca=01, alusrcb=01 (precomputes the branch target).
  - MEMADR: alusrca=10, alusrcb=01.
  - MEMREAD: adrsrc=1.
  - MEMWB: resultsrc=01, regwrite=1.
  - MEMWRITE: adrsrc=1, memwrite=1.
  - EXECUTER: alusrca=10, aluop=10.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=10.
  - ALUWB: regwrite=1.
  - BEQ: alusrca=10, aluop=01, branch=1.
  - JAL: alusrca=01, alusrcb=10, pcupdate=1.
- Transitions:
  - FETCH → DECODE.
  - DECODE by `op`: 0000011 or 0100011 → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1101111 → JAL; 1100011 → BEQ; any other value → FETCH with `illegal`=1.
  - MEMADR → MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD → MEMWB → FETCH.
  - MEMWRITE → FETCH.
  - EXECUTER/EXECUTEI → ALUWB → FETCH.
  - JAL → ALUWB.
  - BEQ → FETCH.
- `pcwrite` = pcupdate | (branch & zero).
- `immsrc` decodes from `op` in every state: lw/I-type 00, sw 01, beq 10, jal 11, all others 00.
- `alucontrol` by aluop:
  - 00 → add.
  - 01 → sub.
  - 10 → by funct3: 000 gives sub if op[5] & funct7b5, else add; 010 → slt; 110 → or; 111 → and; any other value → add.

## Timing
- State register updates on the rising edge of `clk`. All outputs are combinational from state plus `op`/`funct3`/`funct7b5`/`zero`. No output registers.
- Cycles per instruction, FETCH through the last state: lw 5; sw, R-type, I-type and jal 4; beq 3; illegal 2.
- While `reset`=1:
  - state = FETCH.
  - `irwrite`, `pcwrite`, `regwrite`, `memwrite` and `illegal` are forced to 0.
  - Mux selects show the FETCH values.
- After `reset` deasserts, the first rising edge latches the FETCH strobes, i.e. the first instruction is fetched.
- Reset asserted mid-instruction aborts it immediately. A `memwrite` or `regwrite` that is high drops the same cycle, combinationally.
- `zero` is sampled only in BEQ. In BEQ, `pcwrite` follows `zero` in the same cycle.
- Unknown state encodings recover to FETCH on the next edge.

## Structure
- Shared header `riscv_defs.vh`:
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ.
  - 4-bit state encodings.
  - ALUOp and ALU control codes. The datapath ALU uses the same codes.
- One natural sub-module: `aludec` (combinational aluop/funct3/funct7b5/op[5] → `alucontrol`).
- Keep the immsrc decode and the FSM in the top.

## Test plan
- Reset held 3 cycles, then released: all strobes are 0 during reset. The cycle after release shows irwrite=1, pcwrite=1, alusrcb=10, resultsrc=10.
- lw, op=0000011: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. Required responses:
  - adrsrc=1 in MEMREAD.
  - regwrite=1 with resultsrc=01 only in cycle 5.
  - immsrc=00 throughout.
- sw, op=0100011: memwrite=1 exactly once, in cycle 4; immsrc=01; regwrite never asserted.
- R-type sub, funct3=000 with funct7b5=1: alucontrol=001 in EXECUTER. The same stimulus with op=0010011 (addi) gives alucontrol=000.
- beq, op=1100011:
  - zero=1 → pcwrite=1 in cycle 3.
  - zero=0 → pcwrite=0.
  - Both cases: immsrc=10 and alucontrol=001.
- Illegal op 0000000: `illegal` pulses in DECODE and the FSM returns to FETCH. Separately, reset asserted during MEMWRITE drops memwrite within the same cycle.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle RV32I controller: opcodes, state
// encodings, ALUOp / ALU control codes and the datapath mux select values.
package multicycle_control_fsm_pkg;

    // Supported opcodes (instr[6:0])
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    // ALUOp from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU control codes, shared with the datapath ALU
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate formats
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALU A / B sources
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Result mux and memory address mux
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEMDAT = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_RESULT = 1'b1;

    // Immediate format chosen purely from the opcode, independent of state
    function automatic logic [1:0] imm_decode(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_SW:   imm = IMM_S;
            OP_BEQ:  imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_aludec.sv
// ALU decoder: maps ALUOp plus funct3/funct7b5/op[5] to the ALU control code.
module multicycle_control_fsm_aludec
    import multicycle_control_fsm_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       opb5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // only R-type with funct7b5 set is a subtract; addi never is
                    3'b000:  alucontrol = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore main controller for the multicycle RV32I subset: sequences
// fetch/decode/execute/memory/writeback over a shared ALU and memory port.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic [1:0] immsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       adrsrc,
    output logic [2:0] alucontrol,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       illegal
);

    state_t     state_reg;
    state_t     state_next;

    logic [1:0] alusrca_next;
    logic [1:0] alusrcb_next;
    logic [1:0] resultsrc_next;
    logic       adrsrc_next;
    logic [1:0] aluop_next;
    logic       irwrite_next;
    logic       pcupdate_next;
    logic       branch_next;
    logic       regwrite_next;
    logic       memwrite_next;
    logic       illegal_next;
    logic [1:0] aluop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = S_FETCH;
        alusrca_next   = SRCA_PC;
        alusrcb_next   = SRCB_RS2;
        resultsrc_next = RES_ALUOUT;
        adrsrc_next    = ADR_PC;
        aluop_next     = ALUOP_ADD;
        irwrite_next   = 1'b0;
        pcupdate_next  = 1'b0;
        branch_next    = 1'b0;
        regwrite_next  = 1'b0;
        memwrite_next  = 1'b0;
        illegal_next   = 1'b0;

        case (state_reg)
            S_FETCH: begin
                irwrite_next   = 1'b1;
                pcupdate_next  = 1'b1;
                alusrcb_next   = SRCB_FOUR;
                resultsrc_next = RES_ALU;
                state_next     = S_DECODE;
            end
            S_DECODE: begin
                // branch target precomputed here while the register file is read
                alusrca_next = SRCA_OLDPC;
                alusrcb_next = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECUTER;
                    OP_I:         state_next = S_EXECUTEI;
                    OP_JAL:       state_next = S_JAL;
                    OP_BEQ:       state_next = S_BEQ;
                    default: begin
                        state_next   = S_FETCH;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_next = SRCA_RS1;
                alusrcb_next = SRCB_IMM;
                state_next   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrsrc_next = ADR_RESULT;
                state_next  = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc_next = RES_MEMDAT;
                regwrite_next  = 1'b1;
                state_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc_next   = ADR_RESULT;
                memwrite_next = 1'b1;
                state_next    = S_FETCH;
            end
            S_EXECUTER: begin
                alusrca_next = SRCA_RS1;
                aluop_next   = ALUOP_FUNCT;
                state_next   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alusrca_next = SRCA_RS1;
                alusrcb_next = SRCB_IMM;
                aluop_next   = ALUOP_FUNCT;
                state_next   = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_next = 1'b1;
                state_next    = S_FETCH;
            end
            S_BEQ: begin
                alusrca_next = SRCA_RS1;
                aluop_next   = ALUOP_SUB;
                branch_next  = 1'b1;
                state_next   = S_FETCH;
            end
            S_JAL: begin
                alusrca_next  = SRCA_OLDPC;
                alusrcb_next  = SRCB_FOUR;
                pcupdate_next = 1'b1;
                state_next    = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // While reset is high the selects show FETCH values and every strobe is held low
    assign alusrca   = reset ? SRCA_PC   : alusrca_next;
    assign alusrcb   = reset ? SRCB_FOUR : alusrcb_next;
    assign resultsrc = reset ? RES_ALU   : resultsrc_next;
    assign adrsrc    = reset ? ADR_PC    : adrsrc_next;
    assign aluop     = reset ? ALUOP_ADD : aluop_next;

    assign irwrite  = irwrite_next  & ~reset;
    assign pcwrite  = (pcupdate_next | (branch_next & zero)) & ~reset;
    assign regwrite = regwrite_next & ~reset;
    assign memwrite = memwrite_next & ~reset;
    assign illegal  = illegal_next  & ~reset;

    assign immsrc = imm_decode(op);

    multicycle_control_fsm_aludec u_aludec (
        .aluop      (aluop),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .opb5       (op[5]),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed-vector bench for multicycle_control_fsm: stimulus pushes the
// hand-computed per-cycle outputs into a queue, a monitor pops and compares.
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic [4:0] strobes;    // {irwrite, pcwrite, regwrite, memwrite, illegal}
        logic [1:0] immsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       adrsrc;
        logic [2:0] alucontrol;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic [1:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic [2:0] alucontrol;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       illegal;

    exp_t  exp_q[$];
    string name_q[$];
    int    vectors;
    int    miscompares;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] BAD = 7'b0000000;

    multicycle_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .immsrc     (immsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .resultsrc  (resultsrc),
        .adrsrc     (adrsrc),
        .alucontrol (alucontrol),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [4:0] s, input logic [1:0] imm,
                                input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] r, input logic adr,
                                input logic [2:0] alu);
        exp_t e;
        e.strobes    = s;
        e.immsrc     = imm;
        e.alusrca    = a;
        e.alusrcb    = b;
        e.resultsrc  = r;
        e.adrsrc     = adr;
        e.alucontrol = alu;
        return e;
    endfunction

    // One clock cycle: drive inputs just after the edge and queue the expected outputs
    task automatic cyc(input string name, input logic rst, input logic [6:0] o,
                       input logic [2:0] f3, input logic f7, input logic z,
                       input exp_t e);
        @(posedge clk);
        #1;
        reset    = rst;
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        zero     = z;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // Monitor: outputs are combinational and valid every cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t  e;
            exp_t  got;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            got.strobes    = {irwrite, pcwrite, regwrite, memwrite, illegal};
            got.immsrc     = immsrc;
            got.alusrca    = alusrca;
            got.alusrcb    = alusrcb;
            got.resultsrc  = resultsrc;
            got.adrsrc     = adrsrc;
            got.alucontrol = alucontrol;
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL %s: got strobes=%b imm=%b a=%b b=%b res=%b adr=%b alu=%b, required strobes=%b imm=%b a=%b b=%b res=%b adr=%b alu=%b",
                         nm, got.strobes, got.immsrc, got.alusrca, got.alusrcb, got.resultsrc,
                         got.adrsrc, got.alucontrol, e.strobes, e.immsrc, e.alusrca, e.alusrcb,
                         e.resultsrc, e.adrsrc, e.alucontrol);
            end else begin
                $display("ok   %s: strobes=%b imm=%b a=%b b=%b res=%b adr=%b alu=%b",
                         nm, got.strobes, got.immsrc, got.alusrca, got.alusrcb, got.resultsrc,
                         got.adrsrc, got.alucontrol);
            end
        end
    end

    initial begin
        int guard;
        vectors     = 0;
        miscompares = 0;
        reset    = 1'b1;
        op       = BAD;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        zero     = 1'b0;

        // reset held three cycles: strobes low, selects at FETCH values
        for (int i = 0; i < 3; i++)
            cyc("reset_hold", 1, BAD, 3'b000, 0, 0, mk(5'b00000, 2'b00, 2'b00, 2'b10, 2'b10, 0, 3'b000));

        // lw: FETCH DECODE MEMADR MEMREAD MEMWB
        cyc("lw_fetch",   0, LW, 3'b010, 0, 0, mk(5'b11000, 2'b00, 2'b00, 2'b10, 2'b10, 0, 3'b000));
        cyc("lw_decode",  0, LW, 3'b010, 0, 0, mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 0, 3'b000));
        cyc("lw_memadr",  0, LW, 3'b010, 0, 0, mk(5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b000));
        cyc("lw_memread", 0, LW, 3'b010, 0, 0, mk(5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000));
        cyc("lw_memwb",   0, LW, 3'b010, 0, 0, mk(5'b00100, 2'b00, 2'b00, 2'b00, 2'b01, 0, 3'b000));

        // sw: FETCH DECODE MEMADR MEMWRITE
        cyc("sw_fetch",    0, SW, 3'b010, 0, 0, mk(5'b11000, 2'b01, 2'b00, 2'b10, 2'b10, 0, 3'b000));
        cyc("sw_decode",   0, SW, 3'b010, 0, 0, mk(5'b00000, 2'b01, 2'b01, 2'b01, 2'b00, 0, 3'b000));
        cyc("sw_memadr",   0, SW, 3'b010, 0, 0, mk(5'b00000, 2'b01, 2'b10, 2'b01, 2'b00, 0, 3'b000));
        cyc("sw_memwrite", 0, SW, 3'b010, 0, 0, mk(5'b00010, 2'b01, 2'b00, 2'b00, 2'b00, 1, 3'b000));

        // R-type sub
        cyc("sub_fetch",  0, RT, 3'b000, 1, 0, mk(5'b11000, 2'b00, 2'b00, 2'b10, 2'b10, 0, 3'b000));
        cyc("sub_decode", 0, RT, 3'b000, 1, 0, mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 0, 3'b000));
        cyc("sub_exec",   0, RT, 3'b000, 1, 0, mk(5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 0, 3'b001));
        cyc("sub_aluwb",  0, RT, 3'b000, 1, 0, mk(5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000));

        // addi with funct7b5=1 still adds
        cyc("addi_fetch",  0, IT, 3'b000, 1, 0, mk(5'b11000, 2'b00, 2'b00, 2'b10, 2'b10, 0, 3'b000));
        cyc("addi_decode", 0, IT, 3'b000, 1, 0, mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 0, 3'b000));
        cyc("addi_exec",   0, IT, 3'b000, 1, 0, mk(5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b000));
        cyc("addi_aluwb",  0, IT, 3'b000, 1, 0, mk(5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000));

        // R-type and / slt, I-type ori and sll-like fallback: EXECUTE cycle only shown distinct
        cyc("and_fetch",  0, RT, 3'b111, 0, 0, mk(5'b11000, 2'b00, 2'b00, 2'b10, 2'b10, 0, 3'b000));
        cyc("and_decode", 0, RT, 3'b111, 0, 0, mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 0, 3'b000));
        cyc("and_exec",   0, RT, 3'b111, 0, 0, mk(5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 0, 3'b010));
        cyc("and_aluwb",  0, RT, 3'b111, 0, 0, mk(5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000));
        cyc("slt_fetch",  0, RT, 3'b010, 0, 0, mk(5'b11000, 2'b00, 2'b00, 2'b10, 2'b10, 0, 3'b000));
        cyc("slt_decode", 0, RT, 3'b010, 0, 0, mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 0, 3'b000));
        cyc("slt_exec",   0, RT, 3'b010, 0, 0, mk(5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 0, 3'b101));
        cyc("slt_aluwb",  0, RT, 3'b010, 0, 0, mk(5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000));
        cyc("ori_fetch",  0, IT, 3'b110, 0, 0, mk(5'b11000, 2'b00, 2'b00, 2'b10, 2'b10, 0, 3'b000));
        cyc("ori_decode", 0, IT, 3'b110, 0, 0, mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 0, 3'b000));
        cyc("ori_exec",   0, IT, 3'b110, 0, 0, mk(5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b011));
        cyc("ori_aluwb",  0, IT, 3'b110, 0, 0, mk(5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000));
        cyc("f3x_fetch",  0, IT, 3'b001, 1, 0, mk(5'b11000, 2'b00, 2'b00, 2'b10, 2'b10, 0, 3'b000));
        cyc("f3x_decode", 0, IT, 3'b001, 1, 0, mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 0, 3'b000));
        cyc("f3x_exec",   0, IT, 3'b001, 1, 0, mk(5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b000));
        cyc("f3x_aluwb",  0, IT, 3'b001, 1, 0, mk(5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000));

        // beq taken: zero held high, only BEQ may use it
        cyc("beqt_fetch",  0, BEQ, 3'b000, 0, 1, mk(5'b11000, 2'b10, 2'b00, 2'b10, 2'b10, 0, 3'b000));
        cyc("beqt_decode", 0, BEQ, 3'b000, 0, 1, mk(5'b00000, 2'b10, 2'b01, 2'b01, 2'b00, 0, 3'b000));
        cyc("beqt_beq",    0, BEQ, 3'b000, 0, 1, mk(5'b01000, 2'b10, 2'b10, 2'b00, 2'b00, 0, 3'b001));
        // beq not taken
        cyc("beqn_fetch",  0, BEQ, 3'b000, 0, 0, mk(5'b11000, 2'b10, 2'b00, 2'b10, 2'b10, 0, 3'b000));
        cyc("beqn_decode", 0, BEQ, 3'b000, 0, 0, mk(5'b00000, 2'b10, 2'b01, 2'b01, 2'b00, 0, 3'b000));
        cyc("beqn_beq",    0, BEQ, 3'b000, 0, 0, mk(5'b00000, 2'b10, 2'b10, 2'b00, 2'b00, 0, 3'b001));

        // jal: FETCH DECODE JAL ALUWB
        cyc("jal_fetch",  0, JAL, 3'b000, 0, 1, mk(5'b11000, 2'b11, 2'b00, 2'b10, 2'b10, 0, 3'b000));
        cyc("jal_decode", 0, JAL, 3'b000, 0, 1, mk(5'b00000, 2'b11, 2'b01, 2'b01, 2'b00, 0, 3'b000));
        cyc("jal_jal",    0, JAL, 3'b000, 0, 1, mk(5'b01000, 2'b11, 2'b01, 2'b10, 2'b00, 0, 3'b000));
        cyc("jal_aluwb",  0, JAL, 3'b000, 0, 1, mk(5'b00100, 2'b11, 2'b00, 2'b00, 2'b00, 0, 3'b000));

        // illegal opcode: pulse in DECODE, then back to FETCH
        cyc("ill_fetch",  0, BAD, 3'b000, 0, 0, mk(5'b11000, 2'b00, 2'b00, 2'b10, 2'b10, 0, 3'b000));
        cyc("ill_decode", 0, BAD, 3'b000, 0, 0, mk(5'b00001, 2'b00, 2'b01, 2'b01, 2'b00, 0, 3'b000));
        cyc("ill_refetch",0, BAD, 3'b000, 0, 0, mk(5'b11000, 2'b00, 2'b00, 2'b10, 2'b10, 0, 3'b000));
        cyc("ill_after",  0, BAD, 3'b000, 0, 0, mk(5'b00001, 2'b00, 2'b01, 2'b01, 2'b00, 0, 3'b000));

        // sw aborted by reset in MEMWRITE: memwrite must never show
        cyc("swr_fetch",   0, SW, 3'b010, 0, 0, mk(5'b11000, 2'b01, 2'b00, 2'b10, 2'b10, 0, 3'b000));
        cyc("swr_decode",  0, SW, 3'b010, 0, 0, mk(5'b00000, 2'b01, 2'b01, 2'b01, 2'b00, 0, 3'b000));
        cyc("swr_memadr",  0, SW, 3'b010, 0, 0, mk(5'b00000, 2'b01, 2'b10, 2'b01, 2'b00, 0, 3'b000));
        cyc("swr_reset",   1, SW, 3'b010, 0, 0, mk(5'b00000, 2'b01, 2'b00, 2'b10, 2'b10, 0, 3'b000));
        cyc("swr_hold",    1, SW, 3'b010, 0, 0, mk(5'b00000, 2'b01, 2'b00, 2'b10, 2'b10, 0, 3'b000));
        cyc("swr_refetch", 0, SW, 3'b010, 0, 0, mk(5'b11000, 2'b01, 2'b00, 2'b10, 2'b10, 0, 3'b000));
        cyc("swr_redecode",0, SW, 3'b010, 0, 0, mk(5'b00000, 2'b01, 2'b01, 2'b01, 2'b00, 0, 3'b000));

        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
